// File: rtl/camera_line_grabber.sv
// Pixel-clock front end for the MT9V034 path: qualifies FRAME_VALID/LINE_VALID/DATA_IN
// into a coordinate-tagged pixel stream and captures one selected line (8 MSBs) for a slower reader.
module camera_line_grabber #(
  parameter  int COLUMNS = 752,
  parameter  int LINES   = 480,
  localparam int CW      = (COLUMNS > 2) ? $clog2(COLUMNS) : 1,
  localparam int LW      = (LINES > 2) ? $clog2(LINES) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FRAME_VALID,
  input  logic          LINE_VALID,
  input  logic [9:0]    DATA_IN,
  input  logic [LW-1:0] INTERESTING_LINE,
  input  logic [CW-1:0] READ_ADDRESS,
  input  logic          RESET_READY_FLAG,
  output logic [9:0]    PIXEL_OUT,
  output logic [LW-1:0] CURRENT_LINE,
  output logic [CW-1:0] CURRENT_COLUMN,
  output logic          PIXEL_VALID,
  output logic          WHOLE_LINE_READY_FLAG,
  output logic [7:0]    LINE_DATA_OUT
);

  // Counters carry one extra bit so they can hold COLUMNS/LINES themselves and saturate there.
  localparam logic [CW:0]   COL_LIMIT  = (CW+1)'(COLUMNS);
  localparam logic [LW:0]   LINE_LIMIT = (LW+1)'(LINES);
  localparam logic [CW:0]   COL_ONE    = (CW+1)'(1);
  localparam logic [LW:0]   LINE_ONE   = (LW+1)'(1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } arm_state_t;

  arm_state_t  arm_state;
  logic [CW:0] col_cnt;
  logic [LW:0] line_cnt;
  logic        lv_prev;

  logic        in_range;
  logic        ram_we;
  logic        last_col;

  logic [7:0]  line_ram [COLUMNS];

  // NOTE: plain continuous assigns have no hold path, so no latch can be inferred here.
  assign in_range = (col_cnt < COL_LIMIT) && (line_cnt < LINE_LIMIT);
  assign ram_we   = !RESET && PIXEL_VALID && !WHOLE_LINE_READY_FLAG &&
                    (CURRENT_LINE == INTERESTING_LINE);
  assign last_col = (CURRENT_COLUMN == COL_LAST);

  // Arming and pixel qualification. A frame already running when we leave reset is skipped
  // because arming needs FRAME_VALID to be seen low first.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_state      <= UNARMED;
      col_cnt        <= '0;
      line_cnt       <= '0;
      lv_prev        <= 1'b0;
      PIXEL_OUT      <= '0;
      CURRENT_LINE   <= '0;
      CURRENT_COLUMN <= '0;
      PIXEL_VALID    <= 1'b0;
    end else begin
      lv_prev     <= LINE_VALID;
      PIXEL_VALID <= 1'b0;
      if (!FRAME_VALID) begin
        arm_state <= ARMED;
        col_cnt   <= '0;
        line_cnt  <= '0;
      end else if (arm_state == ARMED) begin
        if (LINE_VALID) begin
          PIXEL_OUT      <= DATA_IN;
          CURRENT_LINE   <= line_cnt[LW-1:0];
          CURRENT_COLUMN <= col_cnt[CW-1:0];
          PIXEL_VALID    <= in_range;
          if (col_cnt < COL_LIMIT) begin
            col_cnt <= col_cnt + COL_ONE;
          end
        end else begin
          col_cnt <= '0;
          if (lv_prev && (line_cnt < LINE_LIMIT)) begin
            line_cnt <= line_cnt + LINE_ONE;
          end
        end
      end
    end
  end

  // Ready flag: a clear request beats a simultaneous final-column write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WHOLE_LINE_READY_FLAG <= 1'b0;
    end else if (RESET_READY_FLAG) begin
      WHOLE_LINE_READY_FLAG <= 1'b0;
    end else if (ram_we && last_col) begin
      WHOLE_LINE_READY_FLAG <= 1'b1;
    end
  end

  // NOTE: the line buffer has no reset so it maps onto plain block RAM; consumers only read after the flag.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      line_ram[CURRENT_COLUMN] <= PIXEL_OUT[9:2];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LINE_DATA_OUT <= '0;
    end else if ({1'b0, READ_ADDRESS} < COL_LIMIT) begin
      LINE_DATA_OUT <= line_ram[READ_ADDRESS];
    end else begin
      LINE_DATA_OUT <= '0;
    end
  end

endmodule

// File: tb/tb_camera_line_grabber.sv
// Bench for camera_line_grabber on a 2x3 geometry: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference of pixel coordinates and the line buffer.
module tb_camera_line_grabber;

  localparam int COLUMNS = 2;
  localparam int LINES   = 3;
  localparam int CW      = 1;
  localparam int LW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic          line_valid;
  logic [9:0]    data_in;
  logic [LW-1:0] interesting_line;
  logic [CW-1:0] read_address;
  logic          reset_ready_flag;
  logic [9:0]    pixel_out;
  logic [LW-1:0] current_line;
  logic [CW-1:0] current_column;
  logic          pixel_valid;
  logic          whole_line_ready_flag;
  logic [7:0]    line_data_out;

  always #5 clk = ~clk;

  camera_line_grabber #(.COLUMNS(COLUMNS), .LINES(LINES)) dut (
    .CLK                  (clk),
    .RESET                (reset),
    .FRAME_VALID          (frame_valid),
    .LINE_VALID           (line_valid),
    .DATA_IN              (data_in),
    .INTERESTING_LINE     (interesting_line),
    .READ_ADDRESS         (read_address),
    .RESET_READY_FLAG     (reset_ready_flag),
    .PIXEL_OUT            (pixel_out),
    .CURRENT_LINE         (current_line),
    .CURRENT_COLUMN       (current_column),
    .PIXEL_VALID          (pixel_valid),
    .WHOLE_LINE_READY_FLAG(whole_line_ready_flag),
    .LINE_DATA_OUT        (line_data_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference: captured line contents, ready flag, and the pixel presented last cycle.
  logic [7:0] m_ram [COLUMNS];
  bit         m_flag;
  bit         pend_en;
  int         pend_line;
  int         pend_col;
  logic [7:0] pend_val;

  logic [9:0] frame_pix [8][8];
  int         f_lines;
  int         f_pix;
  int         rrf_after_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards apply to the reference whatever buffer write/flag change that edge implies.
  task automatic tick();
    bit wr;
    @(posedge clk);
    #1;
    if (reset) begin
      m_flag = 1'b0;
    end else begin
      wr = pend_en && (pend_line == int'(interesting_line)) && !m_flag;
      if (wr) m_ram[pend_col] = pend_val;
      if (reset_ready_flag) m_flag = 1'b0;
      else if (wr && pend_col == COLUMNS - 1) m_flag = 1'b1;
    end
    pend_en = 1'b0;
  endtask

  task automatic pixel_step(input int l, input int c, input logic [9:0] v);
    bit exp_valid;
    frame_valid = 1'b1;
    line_valid  = 1'b1;
    data_in     = v;
    tick();
    exp_valid = (l < LINES) && (c < COLUMNS);
    check("pix_valid", pixel_valid, exp_valid);
    if (exp_valid) begin
      check("pix_data", pixel_out, v);
      check("pix_line", current_line, l);
      check("pix_col", current_column, c);
      pend_en   = 1'b1;
      pend_line = l;
      pend_col  = c;
      pend_val  = v[9:2];
    end
    check("pix_flag", whole_line_ready_flag, m_flag);
  endtask

  task automatic send_frame();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    tick();
    tick();
    check("idle_valid", pixel_valid, 1'b0);
    frame_valid = 1'b1;
    tick();
    for (int l = 0; l < f_lines; l++) begin
      for (int c = 0; c < f_pix; c++) pixel_step(l, c, frame_pix[l][c]);
      line_valid       = 1'b0;
      reset_ready_flag = (l == rrf_after_line);
      tick();
      reset_ready_flag = 1'b0;
      check("gap_valid", pixel_valid, 1'b0);
      check("gap_flag", whole_line_ready_flag, m_flag);
    end
    frame_valid = 1'b0;
    tick();
  endtask

  task automatic read_check(input int a);
    read_address = CW'(a);
    tick();
    check("read", line_data_out, m_ram[a]);
  endtask

  task automatic clear_flag();
    reset_ready_flag = 1'b1;
    tick();
    reset_ready_flag = 1'b0;
    check("flag_clear", whole_line_ready_flag, m_flag);
  endtask

  task automatic load_plan_frame(input int l1a, input int l1b);
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++) frame_pix[l][c] = 10'($urandom);
    frame_pix[0][0] = 10'(11 << 2);
    frame_pix[0][1] = 10'(12 << 2);
    frame_pix[1][0] = 10'(l1a << 2);
    frame_pix[1][1] = 10'(l1b << 2);
    frame_pix[2][0] = 10'(31 << 2);
    frame_pix[2][1] = 10'(32 << 2);
    f_lines        = 3;
    f_pix          = 2;
    rrf_after_line = -1;
  endtask

  initial begin
    reset            = 1'b1;
    frame_valid      = 1'b1;
    line_valid       = 1'b1;
    data_in          = 10'h155;
    interesting_line = LW'(1);
    read_address     = '0;
    reset_ready_flag = 1'b0;
    m_flag           = 1'b0;
    pend_en          = 1'b0;
    tick();
    tick();
    check("rst_pixel", pixel_out, 10'd0);
    check("rst_line", current_line, 2'd0);
    check("rst_col", current_column, 1'd0);
    check("rst_valid", pixel_valid, 1'b0);
    check("rst_flag", whole_line_ready_flag, 1'b0);
    check("rst_rdata", line_data_out, 8'd0);

    // Frame already running at reset release must be ignored.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = 10'($urandom);
      tick();
      check("prearm_valid", pixel_valid, 1'b0);
      check("prearm_flag", whole_line_ready_flag, 1'b0);
    end

    load_plan_frame(21, 22);
    send_frame();
    read_check(0);
    check("plan_read0", m_ram[0], line_data_out);
    read_check(1);
    read_check(0);

    // Flag still set: new line 1 content must not reach the buffer.
    load_plan_frame(41, 42);
    send_frame();
    read_check(0);
    read_check(1);
    clear_flag();
    send_frame();
    read_check(0);
    read_check(1);

    // Out-of-range lines/columns: interesting line 3 never yields valid pixels.
    clear_flag();
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++) frame_pix[l][c] = 10'($urandom);
    interesting_line = LW'(3);
    f_lines = 5;
    f_pix   = 4;
    send_frame();
    read_check(0);
    read_check(1);
    interesting_line = LW'(1);
    f_lines = 4;
    send_frame();
    read_check(0);
    read_check(1);

    // Clear request on the same edge as the final-column write: clear wins, write blocked.
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++) frame_pix[l][c] = 10'($urandom);
    f_lines        = 3;
    f_pix          = 2;
    rrf_after_line = 1;
    send_frame();
    rrf_after_line = -1;
    read_check(0);
    read_check(1);
    send_frame();
    read_check(0);
    read_check(1);

    // Reset in the middle of a line; the rest of that frame is ignored.
    clear_flag();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    tick();
    frame_valid = 1'b1;
    tick();
    pixel_step(0, 0, 10'h2a7);
    reset = 1'b1;
    tick();
    check("midrst_pixel", pixel_out, 10'd0);
    check("midrst_line", current_line, 2'd0);
    check("midrst_col", current_column, 1'd0);
    check("midrst_valid", pixel_valid, 1'b0);
    check("midrst_flag", whole_line_ready_flag, m_flag);
    check("midrst_rdata", line_data_out, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      line_valid = (i != 2);
      data_in    = 10'($urandom);
      tick();
      check("midrst_ignored", pixel_valid, 1'b0);
    end
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++) frame_pix[l][c] = 10'($urandom);
    send_frame();
    read_check(0);
    read_check(1);

    // Randomized frames with random geometry and selected line.
    for (int it = 0; it < 6; it++) begin
      clear_flag();
      interesting_line = LW'($urandom_range(0, 3));
      f_lines = $urandom_range(2, 5);
      f_pix   = $urandom_range(1, 3);
      for (int l = 0; l < 8; l++)
        for (int c = 0; c < 8; c++) frame_pix[l][c] = 10'($urandom);
      send_frame();
      read_check($urandom_range(0, 1));
      read_check(0);
      read_check(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_line_grabber.md
# camera_line_grabber

Pixel-clock front end for the MT9V034 sensor path. It qualifies the raw sensor stream (FRAME_VALID/LINE_VALID/10-bit data) into a pixel stream with line/column coordinates. It also captures one selected line (8 MSBs per pixel) into an internal line buffer that downstream logic reads at its own pace after a ready flag. It sits directly behind the sensor pins and feeds the image-processing consumers.

## Interface
- COLUMNS, 752, pixels per line captured; CW = max(1, clog2(COLUMNS))
- LINES, 480, lines per frame tracked; LW = max(1, clog2(LINES))
- CLK  in  1  single clock (pixel clock), all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- FRAME_VALID  in  1  sensor frame strobe
- LINE_VALID  in  1  sensor line strobe
- DATA_IN  in  10  sensor pixel
- INTERESTING_LINE  in  LW  line index to capture
- READ_ADDRESS  in  CW  line-buffer read column
- RESET_READY_FLAG  in  1  clears WHOLE_LINE_READY_FLAG, re-arms capture
- PIXEL_OUT  out  10  registered pixel
- CURRENT_LINE  out  LW  line index of PIXEL_OUT
- CURRENT_COLUMN  out  CW  column index of PIXEL_OUT
- PIXEL_VALID  out  1  PIXEL_OUT/coordinates valid this cycle
- WHOLE_LINE_READY_FLAG  out  1  selected line fully stored
- LINE_DATA_OUT  out  8  line-buffer read data

## Operation
- Arming: after RESET the front end is unarmed; it arms on the first cycle FRAME_VALID is sampled low. A frame already in progress at reset is ignored entirely.
- Armed, FRAME_VALID low: line counter cleared to 0; column counter cleared.
- Pixel sample: a cycle with FRAME_VALID=1 and LINE_VALID=1 (armed) takes DATA_IN. PIXEL_OUT/CURRENT_LINE/CURRENT_COLUMN/PIXEL_VALID=1 are registered on that edge.
  - Column increments per pixel. It resets to 0 when LINE_VALID is low.
  - Line increments on each LINE_VALID falling edge inside the frame.
- Range clipping: pixels with column >= COLUMNS or line >= LINES give PIXEL_VALID=0. Counters saturate and do not wrap.
- Line buffer: COLUMNS x 8-bit RAM.
  - Write occurs when PIXEL_VALID=1, CURRENT_LINE==INTERESTING_LINE and WHOLE_LINE_READY_FLAG=0. It stores PIXEL_OUT[9:2] at CURRENT_COLUMN.
  - The write of column COLUMNS-1 sets WHOLE_LINE_READY_FLAG on the same edge.
  - While the flag is set, writes are blocked, so buffer contents are frozen.
- RESET_READY_FLAG=1 clears the flag on the next edge. Capture resumes with the next occurrence of INTERESTING_LINE (a partially passed line may yield a mixed line; consumers clear between frames).
- Simultaneous RESET_READY_FLAG and final-column write: clear wins; the write is blocked because the flag is still set at that edge.
- Read: LINE_DATA_OUT <= RAM[READ_ADDRESS] every edge. READ_ADDRESS >= COLUMNS returns 0.
- Reset values:
  - PIXEL_OUT, CURRENT_LINE, CURRENT_COLUMN = 0; PIXEL_VALID = 0.
  - WHOLE_LINE_READY_FLAG = 0, LINE_DATA_OUT = 0, unarmed.
  - RAM contents are not reset.
- Reset mid-frame: drop to unarmed; the rest of that frame is ignored.

## Timing
- Sensor inputs sampled at edge N → pixel outputs valid after edge N (1-cycle latency).
- Line-buffer write at edge N+1; WHOLE_LINE_READY_FLAG high after edge N+1 following the last pixel of the selected line.
- READ_ADDRESS at edge M → LINE_DATA_OUT after edge M (1-cycle read latency). Back-to-back reads at one address per cycle.
- Flag cleared after the edge sampling RESET_READY_FLAG=1.

## Test plan
- COLUMNS=2, LINES=3, INTERESTING_LINE=1. FRAME_VALID/LINE_VALID high at reset release for 4 cycles with data → PIXEL_VALID stays 0, no capture.
- Frame: lines {11,12},{21,22},{31,32} (DATA_IN = value<<2), 1 idle cycle between lines → PIXEL_VALID pulses with (line,col) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) and PIXEL_OUT = value<<2. Flag rises one cycle after (1,1).
- After the flag, READ_ADDRESS=0 then 1 → LINE_DATA_OUT=21 then 22, each 1 cycle later.
- Repeat the frame with line 1 = {41,42} without clearing → reads still 21,22. Pulse RESET_READY_FLAG, send next frame → flag re-rises, reads 41,42.
- Fourth line in a frame (line index 3 ≥ LINES) and a third pixel per line → PIXEL_VALID=0 for those; buffer unchanged.
- Assert RESET mid-line → all outputs 0 next cycle; the remaining frame ignored until FRAME_VALID low.
